// File: rtl/fb_branch_resolve_pkg.sv
// Firebird branch resolution: shared types and constants.
// Imported by the condition unit, the handshake interface and the resolver.
package fb_branch_resolve_pkg;

  localparam int FB_XLEN = 32;
  typedef logic [FB_XLEN-1:0] word_t;

  localparam logic [2:0] FB_BEQ  = 3'b000;
  localparam logic [2:0] FB_BNE  = 3'b001;
  localparam logic [2:0] FB_BLT  = 3'b100;
  localparam logic [2:0] FB_BGE  = 3'b101;
  localparam logic [2:0] FB_BLTU = 3'b110;
  localparam logic [2:0] FB_BGEU = 3'b111;

  localparam int FB_NF = 3;
  localparam int FB_ZF = 2;
  localparam int FB_CF = 1;
  localparam int FB_VF = 0;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/fb_branch_resolve_if.sv
// Branch offer and fetch redirect handshakes.
// master: pipeline/fetch side, slave: branch resolver.
interface fb_branch_resolve_if;
  import fb_branch_resolve_pkg::*;

  logic       br_valid;
  logic       br_ready;
  logic [2:0] br_funct3;
  word_t      br_pc;
  word_t      br_imm;
  logic       br_pred_taken;
  logic       redirect_valid;
  logic       redirect_ready;
  word_t      redirect_pc;

  modport master (
    output br_valid, br_funct3, br_pc,
    output br_imm, br_pred_taken,
    output redirect_ready,
    input  br_ready, redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  br_valid, br_funct3, br_pc,
    input  br_imm, br_pred_taken,
    input  redirect_ready,
    output br_ready, redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fb_branch_cond.sv
// RV32I branch condition from {NF,ZF,CF,VF} of op1 - op2.
// Purely combinational; also used by the trace unit.
module fb_branch_cond
  import fb_branch_resolve_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       illegal
);

  logic lt;
  assign lt = flags[FB_NF] ^ flags[FB_VF];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      funct3 == FB_BEQ:  taken = flags[FB_ZF];
      funct3 == FB_BNE:  taken = !flags[FB_ZF];
      funct3 == FB_BLT:  taken = lt;
      funct3 == FB_BGE:  taken = !lt;
      funct3 == FB_BLTU: taken = !flags[FB_CF];
      funct3 == FB_BGEU: taken = flags[FB_CF];
      default:           illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fb_branch_resolve.sv
// EX/MEM branch resolver: flag latch, outcome, target,
// held fetch redirect and saturating mispredict count.
module fb_branch_resolve
  import fb_branch_resolve_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       flag_in,
  input  logic             flag_we,
  input  logic             kill,
  fb_branch_resolve_if.slave bus,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_illegal,
  output logic             res_misalign,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] mispredict_cnt
);

  state_e     state;
  logic [3:0] flags_eff;
  logic       taken;
  logic       illegal;
  logic       misalign;
  logic       mispredict;
  logic       accept;
  word_t      target;

  assign flags_eff = flag_we ? flag_in : flags_q;

  fb_branch_cond u_cond (
    .funct3  (bus.br_funct3),
    .flags   (flags_eff),
    .taken   (taken),
    .illegal (illegal)
  );

  assign target = taken ? bus.br_pc + bus.br_imm
                        : bus.br_pc + 32'd4;
  assign misalign = taken && target[1];
  assign mispredict = (taken != bus.br_pred_taken)
                      && !illegal && !misalign;

  assign bus.br_ready = (state == S_IDLE);
  assign accept = bus.br_valid && bus.br_ready && !kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flag_we) begin
      flags_q <= flag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      res_valid          <= 1'b0;
      res_taken          <= 1'b0;
      res_illegal        <= 1'b0;
      res_misalign       <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      mispredict_cnt     <= '0;
    end else begin
      res_valid    <= 1'b0;
      res_taken    <= 1'b0;
      res_illegal  <= 1'b0;
      res_misalign <= 1'b0;
      if (kill) begin
        state              <= S_IDLE;
        bus.redirect_valid <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (accept) begin
              res_valid    <= 1'b1;
              res_taken    <= taken;
              res_illegal  <= illegal;
              res_misalign <= misalign;
              if (mispredict) begin
                state              <= S_REDIRECT;
                bus.redirect_valid <= 1'b1;
                bus.redirect_pc    <= target;
                if (mispredict_cnt != '1)
                  mispredict_cnt <= mispredict_cnt + CNT_W'(1);
              end
            end
          end
          S_REDIRECT: begin
            if (bus.redirect_ready) begin
              state              <= S_IDLE;
              bus.redirect_valid <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_branch_resolve.sv
// Directed bench for fb_branch_resolve; a second
// 2-bit-counter instance mirrors stimulus to hit saturation.
module tb_fb_branch_resolve;
  import fb_branch_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  flag_in;
  logic        flag_we;
  logic        kill;
  logic        res_valid, res_taken, res_illegal, res_misalign;
  logic [3:0]  flags_q;
  logic [15:0] cnt;
  logic        res_valid2, res_taken2, res_illegal2, res_misalign2;
  logic [3:0]  flags_q2;
  logic [1:0]  cnt2;
  int          vectors = 0;
  int          miscompares = 0;

  fb_branch_resolve_if bus ();
  fb_branch_resolve_if bus2 ();

  assign bus2.br_valid       = bus.br_valid;
  assign bus2.br_funct3      = bus.br_funct3;
  assign bus2.br_pc          = bus.br_pc;
  assign bus2.br_imm         = bus.br_imm;
  assign bus2.br_pred_taken  = bus.br_pred_taken;
  assign bus2.redirect_ready = bus.redirect_ready;

  fb_branch_resolve #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flag_in(flag_in),
    .flag_we(flag_we), .kill(kill), .bus(bus.slave),
    .res_valid(res_valid), .res_taken(res_taken),
    .res_illegal(res_illegal),
    .res_misalign(res_misalign),
    .flags_q(flags_q), .mispredict_cnt(cnt)
  );

  fb_branch_resolve #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flag_in(flag_in),
    .flag_we(flag_we), .kill(kill), .bus(bus2.slave),
    .res_valid(res_valid2), .res_taken(res_taken2),
    .res_illegal(res_illegal2),
    .res_misalign(res_misalign2),
    .flags_q(flags_q2), .mispredict_cnt(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] f3,
                    input logic [31:0] pc,
                    input logic [31:0] imm,
                    input logic pred);
    bus.br_valid      = 1'b1;
    bus.br_funct3     = f3;
    bus.br_pc         = pc;
    bus.br_imm        = imm;
    bus.br_pred_taken = pred;
  endtask

  initial begin
    rst_n = 1'b0;
    flag_in = '0;
    flag_we = 1'b0;
    kill = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_funct3 = '0;
    bus.br_pc = '0;
    bus.br_imm = '0;
    bus.br_pred_taken = 1'b0;
    bus.redirect_ready = 1'b0;
    #12 rst_n = 1'b1;

    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_rv", 32'(bus.redirect_valid), 32'h0);
    chk("rst_rpc", bus.redirect_pc, 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_ready", 32'(bus.br_ready), 32'h1);

    // BEQ with bypassed flags, mispredicted not-taken
    flag_in = 4'b0100;
    flag_we = 1'b1;
    br(FB_BEQ, 32'h100, 32'h20, 1'b0);
    tick();
    flag_we = 1'b0;
    br(FB_BEQ, 32'h900, 32'h20, 1'b0);
    chk("beq_valid", 32'(res_valid), 32'h1);
    chk("beq_taken", 32'(res_taken), 32'h1);
    chk("beq_rv", 32'(bus.redirect_valid), 32'h1);
    chk("beq_rpc", bus.redirect_pc, 32'h120);
    chk("beq_ready", 32'(bus.br_ready), 32'h0);
    chk("beq_cnt", 32'(cnt), 32'h1);
    chk("beq_flags", 32'(flags_q), 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rv", 32'(bus.redirect_valid), 32'h1);
      chk("hold_rpc", bus.redirect_pc, 32'h120);
      chk("hold_ready", 32'(bus.br_ready), 32'h0);
      chk("hold_resv", 32'(res_valid), 32'h0);
    end
    bus.br_valid = 1'b0;
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    chk("hs_rv", 32'(bus.redirect_valid), 32'h0);
    chk("hs_ready", 32'(bus.br_ready), 32'h1);
    chk("hs_cnt", 32'(cnt), 32'h1);

    // back-to-back correctly predicted branches
    flag_in = 4'b1000;
    flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
    chk("flags_1000", 32'(flags_q), 32'h8);
    br(FB_BLT, 32'h200, 32'h40, 1'b1);
    tick();
    chk("blt_valid", 32'(res_valid), 32'h1);
    chk("blt_taken", 32'(res_taken), 32'h1);
    chk("blt_rv", 32'(bus.redirect_valid), 32'h0);
    chk("blt_ready", 32'(bus.br_ready), 32'h1);
    br(FB_BGEU, 32'h300, 32'h40, 1'b0);
    tick();
    bus.br_valid = 1'b0;
    chk("bgeu_valid", 32'(res_valid), 32'h1);
    chk("bgeu_taken", 32'(res_taken), 32'h0);
    chk("bgeu_rv", 32'(bus.redirect_valid), 32'h0);
    chk("bgeu_cnt", 32'(cnt), 32'h1);

    // BNE not taken at top of memory: pc+4 wraps
    flag_in = 4'b0100;
    flag_we = 1'b1;
    br(FB_BNE, 32'hFFFF_FFFC, 32'h40, 1'b1);
    tick();
    flag_we = 1'b0;
    bus.br_valid = 1'b0;
    chk("bne_taken", 32'(res_taken), 32'h0);
    chk("bne_rv", 32'(bus.redirect_valid), 32'h1);
    chk("bne_rpc", bus.redirect_pc, 32'h0);
    chk("bne_cnt", 32'(cnt), 32'h2);

    // kill together with redirect_ready
    kill = 1'b1;
    bus.redirect_ready = 1'b1;
    tick();
    kill = 1'b0;
    bus.redirect_ready = 1'b0;
    chk("kill_rv", 32'(bus.redirect_valid), 32'h0);
    chk("kill_ready", 32'(bus.br_ready), 32'h1);
    chk("kill_cnt", 32'(cnt), 32'h2);

    // illegal funct3, then a misaligned taken target
    br(3'b010, 32'h400, 32'h40, 1'b1);
    tick();
    chk("ill_valid", 32'(res_valid), 32'h1);
    chk("ill_flag", 32'(res_illegal), 32'h1);
    chk("ill_taken", 32'(res_taken), 32'h0);
    chk("ill_rv", 32'(bus.redirect_valid), 32'h0);
    br(FB_BEQ, 32'h400, 32'h2, 1'b0);
    tick();
    bus.br_valid = 1'b0;
    chk("mis_valid", 32'(res_valid), 32'h1);
    chk("mis_flag", 32'(res_misalign), 32'h1);
    chk("mis_taken", 32'(res_taken), 32'h1);
    chk("mis_ill", 32'(res_illegal), 32'h0);
    chk("mis_rv", 32'(bus.redirect_valid), 32'h0);
    chk("mis_cnt", 32'(cnt), 32'h2);

    // kill with an offered branch; flags still latch
    kill = 1'b1;
    flag_in = 4'b0001;
    flag_we = 1'b1;
    br(FB_BEQ, 32'h700, 32'h8, 1'b1);
    tick();
    kill = 1'b0;
    flag_we = 1'b0;
    bus.br_valid = 1'b0;
    chk("kbr_resv", 32'(res_valid), 32'h0);
    chk("kbr_rv", 32'(bus.redirect_valid), 32'h0);
    chk("kbr_flags", 32'(flags_q), 32'h1);
    chk("kbr_cnt", 32'(cnt), 32'h2);

    // two more mispredicts: 2-bit counter saturates
    br(FB_BLT, 32'h500, 32'h10, 1'b0);
    tick();
    bus.br_valid = 1'b0;
    chk("blt2_rv", 32'(bus.redirect_valid), 32'h1);
    chk("blt2_rpc", bus.redirect_pc, 32'h510);
    chk("blt2_cnt", 32'(cnt), 32'h3);
    chk("blt2_cnt2", 32'(cnt2), 32'h3);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    chk("blt2_hs", 32'(bus.redirect_valid), 32'h0);
    br(FB_BGE, 32'h600, 32'h10, 1'b1);
    tick();
    bus.br_valid = 1'b0;
    chk("bge_rv", 32'(bus.redirect_valid), 32'h1);
    chk("bge_rpc", bus.redirect_pc, 32'h604);
    chk("bge_cnt", 32'(cnt), 32'h4);
    chk("sat_cnt2", 32'(cnt2), 32'h3);

    // asynchronous reset while in REDIRECT
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rv", 32'(bus.redirect_valid), 32'h0);
    chk("arst_rpc", bus.redirect_pc, 32'h0);
    chk("arst_resv", 32'(res_valid), 32'h0);
    chk("arst_ready", 32'(bus.br_ready), 32'h1);
    chk("arst_cnt", 32'(cnt), 32'h0);
    chk("arst_cnt2", 32'(cnt2), 32'h0);
    chk("arst_flags", 32'(flags_q), 32'h0);
    #5 rst_n = 1'b1;
    tick();
    chk("post_ready", 32'(bus.br_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_branch_resolve.md
# fb_branch_resolve

Consumer of the ALU status flags {NF, ZF, CF, VF} and their write strobe. Sits at the EX/MEM boundary of the Firebird pipeline. It latches the flags, evaluates the RV32I branch condition for the branch in flight, and computes the real target. On a misprediction it raises a held redirect request toward fetch, and it keeps a saturating mispredict counter.

## Interface
Parameters:
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flag_in  in  4  {NF, ZF, CF, VF} from the ALU, produced by op1 − op2.
- flag_we  in  1  ALU flag write strobe (branch op).
- br_valid  in  1  a branch is offered.
- br_ready  out  1  the branch is accepted when br_valid && br_ready.
- br_funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- br_pc  in  `FB_32BITS  PC of the branch.
- br_imm  in  `FB_32BITS  sign-extended B-immediate.
- br_pred_taken  in  1  the fetch prediction.
- kill  in  1  higher-priority flush (trap or older redirect).
- res_valid  out  1  one-cycle pulse when a branch resolves.
- res_taken  out  1  the actual outcome; valid with res_valid.
- res_illegal  out  1  pulse with res_valid when funct3 is 010 or 011.
- res_misalign  out  1  pulse with res_valid when the taken target has bit1 set.
- redirect_valid  out  1  redirect request to fetch, held until accepted.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  `FB_32BITS  the correct next PC.
- flags_q  out  4  the latched flags.
- mispredict_cnt  out  CNT_W  count of mispredictions, saturating.

## Operation
- Flag register: when flag_we = 1, flags_q ← flag_in. Condition evaluation uses flag_in if flag_we is high in the acceptance cycle, and flags_q otherwise (bypass).
- Conditions:
  - EQ = ZF; NE = !ZF.
  - LT = NF^VF; GE = !(NF^VF).
  - LTU = !CF; GEU = CF.
  - Illegal funct3 resolves not-taken and raises res_illegal.
- Target arithmetic: taken → br_pc + br_imm; not-taken → br_pc + 4. Both are 32-bit and wrap modulo 2^32.
- Mispredict = (res_taken != br_pred_taken) && !illegal && !misalign.
- res_misalign applies to a taken branch only. It suppresses the redirect; the trap is handled by the downstream stage.
- State machine IDLE / REDIRECT:
  - IDLE: br_ready = 1. When a branch is accepted, the resolution registers update on the same edge.
  - On that edge, a mispredict goes to REDIRECT; any other outcome stays in IDLE.
  - REDIRECT: br_ready = 0. redirect_valid = 1 and redirect_pc is held stable.
  - From REDIRECT, go to IDLE on redirect_valid && redirect_ready.
- kill has highest priority:
  - Forces IDLE and clears redirect_valid.
  - Suppresses acceptance in the same cycle, so no res_valid follows.
  - A kill arriving in the same cycle as redirect_ready still clears the redirect; the counter is unaffected.
- mispredict_cnt increments by 1 on every mispredict resolution and saturates at all-ones.
- flags_q is written by flag_we independently of state, including in REDIRECT and during kill.

## Timing
- Reset values: flags_q = 0, state = IDLE, res_valid = res_taken = res_illegal = res_misalign = 0, redirect_valid = 0, redirect_pc = 0, mispredict_cnt = 0. br_ready = 1 after reset.
- Latency: a branch accepted at edge N gives res_valid high during cycle N+1, and redirect_valid from cycle N+1 if mispredicted.
- Throughput: one branch per cycle while predictions are correct. A mispredict blocks new branches until the cycle after the redirect handshake.
- redirect_valid and redirect_pc do not change while waiting for redirect_ready; only kill may drop them.
- br_ready depends only on registered state; there is no combinational path from br_valid.
- Reset asserted mid-REDIRECT returns the block to IDLE immediately (asynchronously).

## Structure
- Shared package (fb_defines.v):
  - `FB_32BITS.
  - funct3 branch codes FB_BEQ … FB_BGEU.
  - Flag bit indices FB_NF=3, FB_ZF=2, FB_CF=1, FB_VF=0.
  - State encodings.
- One natural sub-module: fb_branch_cond, combinational (funct3, flags → taken, illegal). It is reusable by the debug/trace unit.

## Test plan
- BEQ, flags = 0100 with flag_we in the same cycle, pc = 0x100, imm = 0x20, pred = 0 → next cycle res_taken = 1; redirect_valid = 1 with redirect_pc = 0x120; held for 3 cycles with redirect_ready = 0; br_ready = 0 throughout; mispredict_cnt = 1.
- BLT with flags_q = 1000 (NF=1, VF=0), pred = 1 → taken; no redirect. BGEU with CF = 0, pred = 0 → not-taken; no redirect. Back-to-back accepts every cycle.
- BNE not-taken, pred = 1, pc = 0xFFFF_FFFC → redirect_pc = 0x0000_0000 (wrap).
- funct3 = 010 → res_illegal = 1, res_taken = 0, no redirect. Taken branch with imm = 0x2 → res_misalign = 1, no redirect.
- Kill asserted in REDIRECT, in the same cycle as redirect_ready → redirect_valid = 0 next cycle, state IDLE. Kill in the same cycle as br_valid → no res_valid.
- Force mispredict_cnt to 0xFFFF, then cause one more mispredict → the count stays 0xFFFF. Async rst_n pulse mid-REDIRECT → all outputs at reset values without waiting for a clock edge.
